add64_result_checker: RTL and testbench

ADD64_RESULT_CHECKER -- requirements
Module: add64_result_checker

---
 rtl/add64_chk_if.sv | 33 +++
 rtl/add64_result_checker.sv | 121 ++++++++++++
 tb/tb_add64_result_checker.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/add64_chk_if.sv
// Bus between a test-vector source and the 64-bit adder result checker.
// Handshake: a vector (a, b, c0, dut_s, dut_cout) transfers on the rising
// clk edge where in_valid and in_ready are both 1; the source may change
// or drop the vector freely after that edge. Results (exp_s, exp_cout,
// done, error_flag, sticky_err, counters) are outputs of the checker.
interface add64_chk_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        c0;
  logic [63:0] dut_s;
  logic        dut_cout;
  logic [63:0] exp_s;
  logic        exp_cout;
  logic        done;
  logic        error_flag;
  logic        sticky_err;
  logic [15:0] chk_count;
  logic [15:0] err_count;

  modport master (
    output in_valid, a, b, c0, dut_s, dut_cout,
    input  in_ready, exp_s, exp_cout, done, error_flag, sticky_err,
           chk_count, err_count
  );

  modport slave (
    input  in_valid, a, b, c0, dut_s, dut_cout,
    output in_ready, exp_s, exp_cout, done, error_flag, sticky_err,
           chk_count, err_count
  );
endinterface

// File: rtl/add64_result_checker.sv
// Checks a 64-bit adder result against a golden sum computed serially,
// one 8-bit slice per cycle (LSB slice first). A check takes 8 CALC cycles
// plus one REPORT cycle; the checker is back in IDLE on the 10th edge.
module add64_result_checker (
  input  logic        clk,
  input  logic        rst,
  add64_chk_if.slave  bus,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] a_q, b_q, dut_s_q;
  logic        dut_cout_q;
  logic [2:0]  idx_q;
  logic        carry_q;
  logic [63:0] exp_s_q;
  logic        exp_cout_q;
  logic        sticky_q;
  logic [15:0] chk_q;
  logic [15:0] err_q;

  logic [7:0]  a_sl, b_sl;
  logic [8:0]  sum9;
  logic        mismatch;

  // Current slice operands and their 9-bit sum including the running carry.
  always_comb begin
    a_sl     = a_q[{idx_q, 3'b000} +: 8];
    b_sl     = b_q[{idx_q, 3'b000} +: 8];
    sum9     = {1'b0, a_sl} + {1'b0, b_sl} + {8'd0, carry_q};
    mismatch = (exp_s_q != dut_s_q) || (exp_cout_q != dut_cout_q);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and handshake/report outputs.
  always_comb begin
    state_d        = state_q;
    bus.in_ready   = 1'b0;
    bus.done       = 1'b0;
    bus.error_flag = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = CALC;
      end
      CALC: begin
        if (idx_q == 3'd7) state_d = REPORT;
      end
      REPORT: begin
        bus.done       = 1'b1;
        bus.error_flag = mismatch;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Vector capture, serial golden sum, and statistics update on leaving REPORT.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      dut_s_q    <= '0;
      dut_cout_q <= 1'b0;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      exp_s_q    <= '0;
      exp_cout_q <= 1'b0;
      sticky_q   <= 1'b0;
      chk_q      <= '0;
      err_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            dut_s_q    <= bus.dut_s;
            dut_cout_q <= bus.dut_cout;
            idx_q      <= '0;
            carry_q    <= bus.c0;
          end
        end
        CALC: begin
          exp_s_q[{idx_q, 3'b000} +: 8] <= sum9[7:0];
          carry_q <= sum9[8];
          idx_q   <= idx_q + 3'd1;
          // Carry out of the top slice is the adder carry-out only.
          if (idx_q == 3'd7) exp_cout_q <= sum9[8];
        end
        REPORT: begin
          if (chk_q != 16'hFFFF) chk_q <= chk_q + 16'd1;
          if (mismatch) begin
            sticky_q <= 1'b1;
            if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.exp_s      = exp_s_q;
  assign bus.exp_cout   = exp_cout_q;
  assign bus.sticky_err = sticky_q;
  assign bus.chk_count  = chk_q;
  assign bus.err_count  = err_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_add64_result_checker.sv
// Bench for add64_result_checker: directed vectors with hand-computed golden
// sums, an expected-result queue filled at each transfer and drained by a
// monitor that compares on every done pulse.
module tb_add64_result_checker;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         cyc;

  add64_chk_if bus ();

  add64_result_checker dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [65:0] exp_q[$];   // {error_flag, exp_cout, exp_s}
  int          t_q[$];     // cycle number of the transfer edge
  int          n_vec;
  int          n_checks;
  int          n_fail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 64'd1, 64'd0);
        end else begin
          logic [65:0] e;
          int          t;
          e = exp_q.pop_front();
          t = t_q.pop_front();
          check("exp_s",      bus.exp_s,              e[63:0]);
          check("exp_cout",   {63'd0, bus.exp_cout},  {63'd0, e[64]});
          check("error_flag", {63'd0, bus.error_flag}, {63'd0, e[65]});
          // REPORT is the 9th cycle after the transfer edge: 8 edges later.
          check("done_latency", 64'(cyc - t), 64'd8);
        end
      end else if (bus.error_flag) begin
        check("error_without_done", 64'd1, 64'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic c0,
                      input logic [63:0] ds, input logic dc,
                      input logic [63:0] es, input logic ec, input logic ee,
                      input bit hold, input bit push,
                      output int t_cyc, output int busy);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = a; bus.b = b; bus.c0 = c0; bus.dut_s = ds; bus.dut_cout = dc;
    busy = 0;
    n = 0;
    t_cyc = 0;
    while (!bus.in_ready && n < 40) begin
      busy++;
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 64'd0, 64'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    t_cyc = cyc;
    n_vec++;
    if (push) begin
      exp_q.push_back({ee, ec, es});
      t_q.push_back(t_cyc);
    end
    // Scramble the bus after transfer; the checker must ignore it.
    bus.a = {$urandom(), $urandom()};
    bus.b = {$urandom(), $urandom()};
    bus.dut_s = {$urandom(), $urandom()};
    bus.c0 = 1'($urandom_range(0, 1));
    bus.dut_cout = 1'($urandom_range(0, 1));
    bus.in_valid = hold;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      t_q.delete();
    end
    // One more cycle so the counter update on leaving REPORT has landed.
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0, t1, t2, bz;
    cyc = 0; n_vec = 0; n_checks = 0; n_fail = 0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.c0 = 1'b0;
    bus.dut_s = '0; bus.dut_cout = 1'b0;
    rst = 1'b1;

    do_reset();
    check("rst_in_ready",   {63'd0, bus.in_ready},   64'd1);
    check("rst_done",       {63'd0, bus.done},       64'd0);
    check("rst_error_flag", {63'd0, bus.error_flag}, 64'd0);
    check("rst_sticky",     {63'd0, bus.sticky_err}, 64'd0);
    check("rst_chk_count",  {48'd0, bus.chk_count},  64'd0);
    check("rst_err_count",  {48'd0, bus.err_count},  64'd0);
    check("rst_exp_s",      bus.exp_s,               64'd0);
    check("rst_exp_cout",   {63'd0, bus.exp_cout},   64'd0);

    // 1 + all-ones: carry ripples through every slice.
    send(64'h1, 64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h0, 1'b1,
         64'h0, 1'b1, 1'b0, 1'b0, 1'b1, t0, bz);
    drain();
    check("v1_chk_count", {48'd0, bus.chk_count}, 64'd1);
    check("v1_err_count", {48'd0, bus.err_count}, 64'd0);
    check("v1_sticky",    {63'd0, bus.sticky_err}, 64'd0);
    repeat (3) @(negedge clk);
    check("v1_exp_s_hold", bus.exp_s, 64'h0);
    check("v1_exp_cout_hold", {63'd0, bus.exp_cout}, 64'd1);

    // all-ones + AAAA.. + 1 = AAAA.. with carry out.
    send(64'hFFFFFFFFFFFFFFFF, 64'hAAAAAAAAAAAAAAAA, 1'b1, 64'hAAAAAAAAAAAAAAAA, 1'b1,
         64'hAAAAAAAAAAAAAAAA, 1'b1, 1'b0, 1'b0, 1'b1, t0, bz);
    drain();

    // Wrong DUT sum: FF + FF01 + 1 = 10001.
    send(64'hFF, 64'hFF01, 1'b1, 64'h10000, 1'b0,
         64'h10001, 1'b0, 1'b1, 1'b0, 1'b1, t0, bz);
    drain();
    check("v3_err_count", {48'd0, bus.err_count}, 64'd1);
    check("v3_sticky",    {63'd0, bus.sticky_err}, 64'd1);
    check("v3_chk_count", {48'd0, bus.chk_count}, 64'd3);

    send(64'h0, 64'h0, 1'b0, 64'h0, 1'b0,
         64'h0, 1'b0, 1'b0, 1'b0, 1'b1, t0, bz);
    send(64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1, 64'h0, 1'b1,
         64'h0, 1'b1, 1'b0, 1'b0, 1'b1, t0, bz);
    send(64'h8000000000000000, 64'h8000000000000000, 1'b0, 64'h0, 1'b1,
         64'h0, 1'b1, 1'b0, 1'b0, 1'b1, t0, bz);
    send(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0,
         64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, t0, bz);
    // Sum right, carry-out wrong.
    send(64'h1, 64'h1, 1'b0, 64'h2, 1'b1,
         64'h2, 1'b0, 1'b1, 1'b0, 1'b1, t0, bz);
    drain();
    check("v8_chk_count", {48'd0, bus.chk_count}, 64'd8);
    check("v8_err_count", {48'd0, bus.err_count}, 64'd2);

    // Back-to-back with in_valid held high.
    send(64'h1111111111111111, 64'h2222222222222222, 1'b0, 64'h3333333333333333, 1'b0,
         64'h3333333333333333, 1'b0, 1'b0, 1'b1, 1'b1, t0, bz);
    send(64'hF0F0F0F0F0F0F0F0, 64'h0F0F0F0F0F0F0F0F, 1'b1, 64'h0, 1'b1,
         64'h0, 1'b1, 1'b0, 1'b1, 1'b1, t1, bz);
    check("b2b_busy_1", 64'(bz), 64'd9);
    check("b2b_gap_1",  64'(t1 - t0), 64'd10);
    send(64'h00000000FFFFFFFF, 64'h00000000FFFFFFFF, 1'b0, 64'h00000001FFFFFFFE, 1'b0,
         64'h00000001FFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1, t2, bz);
    check("b2b_busy_2", 64'(bz), 64'd9);
    check("b2b_gap_2",  64'(t2 - t1), 64'd10);
    drain();
    check("b2b_chk_count", {48'd0, bus.chk_count}, 64'd11);

    // Reset in the 4th CALC cycle aborts the check.
    send(64'h5, 64'h6, 1'b0, 64'hB, 1'b0,
         64'hB, 1'b0, 1'b0, 1'b0, 1'b0, t0, bz);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready",  {63'd0, bus.in_ready},   64'd1);
    check("abort_chk_count", {48'd0, bus.chk_count},  64'd0);
    check("abort_err_count", {48'd0, bus.err_count},  64'd0);
    check("abort_sticky",    {63'd0, bus.sticky_err}, 64'd0);
    repeat (12) @(negedge clk);
    check("abort_no_count",  {48'd0, bus.chk_count},  64'd0);

    // Reset wins over a handshake in the same cycle.
    bus.in_valid = 1'b1; bus.a = 64'h7; bus.b = 64'h8; bus.c0 = 1'b0;
    bus.dut_s = 64'h0; bus.dut_cout = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check("rst_hs_state", {62'd0, dbg_state}, 64'd0);
    repeat (12) @(negedge clk);
    check("rst_hs_chk_count", {48'd0, bus.chk_count}, 64'd0);

    send(64'h00000000FFFFFFFF, 64'h1, 1'b0, 64'h0000000100000000, 1'b0,
         64'h0000000100000000, 1'b0, 1'b0, 1'b0, 1'b1, t0, bz);
    drain();
    check("post_abort_chk_count", {48'd0, bus.chk_count}, 64'd1);

    // Saturation: preload both counters to all-ones, then one more mismatch.
    force dut.err_q = 16'hFFFF;
    force dut.chk_q = 16'hFFFF;
    @(negedge clk);
    release dut.err_q;
    release dut.chk_q;
    send(64'h7F, 64'h1, 1'b0, 64'h81, 1'b0,
         64'h80, 1'b0, 1'b1, 1'b0, 1'b1, t0, bz);
    drain();
    check("sat_err_count", {48'd0, bus.err_count}, 64'hFFFF);
    check("sat_chk_count", {48'd0, bus.chk_count}, 64'hFFFF);
    check("sat_sticky",    {63'd0, bus.sticky_err}, 64'd1);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

endmodule
